// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: opcode constants and the memory-stage FSM encoding.
package mem_stage_pkg;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_LDW = 6'h23;
  localparam logic [5:0] OP_SDW = 6'h2B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LDW) || (op == OP_SDW);
  endfunction

endpackage

// File: rtl/mem_if_fsm.sv
// Data-memory interface controller: IDLE/BUSY state, request registers and upstream stall.
module mem_if_fsm
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_op_i,
  input  logic        aligned_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        dm_ack_i,
  output logic        busy_o,
  output logic        capture_o,
  output logic        ack_done_o,
  output logic        stall_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o
);

  mem_state_e  state_q, state_d;
  logic        dm_we_q;
  logic [31:0] dm_addr_q, dm_wdata_q;
  logic        capture, busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_op_i && aligned_i) state_d = ST_BUSY;
      ST_BUSY: if (dm_ack_i)              state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Stall drops in the ack cycle so upstream advances on the same edge as the result.
  always_comb begin
    busy       = (state_q == ST_BUSY);
    capture    = (state_q == ST_IDLE) && mem_op_i && aligned_i;
    busy_o     = busy;
    capture_o  = capture;
    ack_done_o = busy && dm_ack_i;
    dm_req_o   = busy;
    stall_o    = capture || (busy && !dm_ack_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
    end else if (capture) begin
      dm_we_q    <= we_i;
      dm_addr_q  <= addr_i;
      dm_wdata_q <= wdata_i;
    end
  end

  assign dm_we_o    = dm_we_q;
  assign dm_addr_o  = dm_addr_q;
  assign dm_wdata_o = dm_wdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage; LDW/SDW go through mem_if_fsm, everything else passes in 1 cycle.
// Optional stall-cycle counter enabled by defining MEM_STALL_CNT_EN.
module mem_stage
  import mem_stage_pkg::*;
`ifdef MEM_STALL_CNT_EN
#(
  parameter int STALL_CNT_W = 32
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [5:0]  opcode_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rt_in,
  input  logic [4:0]  rwd_in,
  input  logic [31:0] pc_in,
  output logic        stall_out,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [5:0]  opcode_out,
  output logic [4:0]  rwd_out,
  output logic [31:0] pc_out,
  output logic [31:0] wb_data_out,
  output logic        reg_we_out,
  output logic        misalign_out
`ifdef MEM_STALL_CNT_EN
  ,output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  logic mem_op, aligned, busy, capture, ack_done;

  assign mem_op  = valid_in && is_mem_op(opcode_in);
  assign aligned = (alu_res_in[1:0] == 2'b00);

  mem_if_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_op_i   (mem_op),
    .aligned_i  (aligned),
    .we_i       (opcode_in == OP_SDW),
    .addr_i     (alu_res_in),
    .wdata_i    (val_rt_in),
    .dm_ack_i   (dm_ack),
    .busy_o     (busy),
    .capture_o  (capture),
    .ack_done_o (ack_done),
    .stall_o    (stall_out),
    .dm_req_o   (dm_req),
    .dm_we_o    (dm_we),
    .dm_addr_o  (dm_addr),
    .dm_wdata_o (dm_wdata)
  );

  logic [31:0] lat_instr_q, lat_pc_q;
  logic [5:0]  lat_opcode_q;
  logic [4:0]  lat_rwd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_instr_q  <= '0;
      lat_pc_q     <= '0;
      lat_opcode_q <= '0;
      lat_rwd_q    <= '0;
    end else if (capture) begin
      lat_instr_q  <= instr_in;
      lat_pc_q     <= pc_in;
      lat_opcode_q <= opcode_in;
      lat_rwd_q    <= rwd_in;
    end
  end

  logic        valid_q, valid_d, misalign_q, misalign_d;
  logic [31:0] instr_q, instr_d, pc_q, pc_d, wb_q, wb_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [4:0]  rwd_q, rwd_d;

  // In IDLE without capture, a memory op can only be a misaligned one.
  always_comb begin
    valid_d    = 1'b0;
    misalign_d = 1'b0;
    instr_d    = instr_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    rwd_d      = rwd_q;
    wb_d       = wb_q;
    if (ack_done) begin
      valid_d  = 1'b1;
      instr_d  = lat_instr_q;
      pc_d     = lat_pc_q;
      opcode_d = lat_opcode_q;
      rwd_d    = lat_rwd_q;
      wb_d     = dm_we ? dm_addr : dm_rdata;
    end else if (!busy && !capture) begin
      valid_d    = valid_in;
      misalign_d = mem_op;
      instr_d    = instr_in;
      pc_d       = pc_in;
      opcode_d   = opcode_in;
      rwd_d      = rwd_in;
      wb_d       = alu_res_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      opcode_q   <= '0;
      rwd_q      <= '0;
      wb_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      rwd_q      <= rwd_d;
      wb_q       <= wb_d;
    end
  end

  assign valid_out    = valid_q;
  assign misalign_out = misalign_q;
  assign instr_out    = instr_q;
  assign pc_out       = pc_q;
  assign opcode_out   = opcode_q;
  assign rwd_out      = rwd_q;
  assign wb_data_out  = wb_q;
  assign reg_we_out   = valid_q && !misalign_q && (opcode_q != OP_SDW) && (rwd_q != 5'd0);

`ifdef MEM_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall_out && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
